rr_lock_arbiter: RTL

//  N-way round-robin arbiter with grant locking, for a single shared resource.

---
 rtl/rr_lock_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-way round-robin arbiter; the owner keeps its grant for as long as it requests.
// Optional macro ARB_HOLD_LIMIT_EN revokes a contended grant after HOLD_MAX cycles and pulses expire.
module rr_lock_arbiter #(
    parameter int  N        = 4,
    parameter int  HOLD_MAX = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           expire
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t         r_state;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;

    logic [N-1:0]   w_cand;
    logic           w_cand_any;
    logic           w_owner_req;
    logic [IDW-1:0] w_win_id;
    logic [N-1:0]   w_win_oh;
    logic [IDW-1:0] w_next_ptr;
    logic           w_take;
    logic           w_drop;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);
    logic [HCW-1:0] r_hold_cnt;
    logic           r_expire;
    logic           w_force;
`endif

    if (N < 2 || N > 16 || HOLD_MAX < 1) begin : g_param_check
        $error("rr_lock_arbiter: N must be 2..16 and HOLD_MAX >= 1");
    end

    // The current owner is masked out, so a releasing owner can never regrant itself.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_cand
        assign w_cand[gi] = req[gi] & ~r_gnt[gi];
    end

    assign w_cand_any  = |w_cand;
    assign w_owner_req = |(req & r_gnt);

    // Scan from the far end toward ptr so the first candidate at or after ptr wins.
    always_comb begin
        w_win_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand[(int'(r_ptr) + k) % N]) begin
                w_win_id = IDW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_win_oh   = N'(1) << w_win_id;
    assign w_next_ptr = (w_win_id == IDW'(N - 1)) ? '0 : w_win_id + 1'b1;

    always_comb begin
        w_take = 1'b0;
        w_drop = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        w_force = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_take = w_cand_any;
            S_OWN: begin
                if (!w_owner_req) begin
                    w_take = w_cand_any;
                    w_drop = !w_cand_any;
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (w_cand_any && r_hold_cnt == HCW'(HOLD_MAX - 1)) begin
                    w_force = 1'b1;
                    w_take  = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
        end else if (w_take) begin
            r_state     <= S_OWN;
            r_gnt       <= w_win_oh;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_win_id;
            r_ptr       <= w_next_ptr;
        end else if (w_drop) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Counts only contended ownership cycles; any new grant or quiet cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_expire   <= 1'b0;
        end else begin
            r_expire <= w_force;
            if (w_take || !w_cand_any || r_state == S_IDLE) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign expire = r_expire;
`else
    assign expire = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule
